sw_job_sequencer: RTL and testbench
===================================

SW_JOB_SEQUENCER -- requirements
Module: sw_job_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: job FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter WD_CYCLES, default 50000000: watchdog limit in cycles, used only with SW_SEQ_WATCHDOG_EN.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_job_valid, input, 1 bit: job push request.
REQ-006 SHALL have port i_job_param, input, 16 bits: job word {match[15:12], mismatch[11:8], minusAlpha[7:4], minusBeta[3:0]}.
REQ-007 SHALL have port o_job_ready, output, 1 bit: FIFO not full.
REQ-008 SHALL have port i_go, input, 1 bit: run request.
REQ-009 SHALL have port o_set_t, output, 1 bit: engine set-target pulse.
REQ-010 SHALL have port o_start_cal, output, 1 bit: engine start pulse.
REQ-011 SHALL have ports o_match, o_mismatch, o_minusAlpha, o_minusBeta, output, 4 bits each: engine scoring parameters.
REQ-012 SHALL have ports i_busy, input, 1 bit; i_valid, input, 1 bit; i_result, input, `V_E_F_Bit bits: engine status and score.
REQ-013 SHALL have ports o_res_valid, output, 1 bit; o_res_data, output, `V_E_F_Bit bits; o_res_idx, output, 4 bits: captured score and its job index.
REQ-014 SHALL have ports o_busy, output, 1 bit: run in progress; o_done, output, 1 bit: one-cycle end-of-run pulse.

Function
REQ-015 A push SHALL occur when i_job_valid && o_job_ready; pushes SHALL be accepted in every state; a push when full SHALL be dropped.
REQ-016 FSM states SHALL be IDLE, SET_T, WAIT_T, LOAD, START, WAIT_RES, WAIT_IDLE, DONE.
REQ-017 IDLE: i_go SHALL move to SET_T; i_go outside IDLE SHALL be ignored.
REQ-018 SET_T: o_set_t SHALL be 1 for exactly one cycle, then WAIT_T.
REQ-019 WAIT_T: i_busy SHALL be ignored for the first cycle; afterwards i_busy==0 SHALL go to LOAD when FIFO non-empty, else DONE.
REQ-020 LOAD: FIFO head SHALL be popped into the parameter outputs; job index counter SHALL advance after each job.
REQ-021 START: o_start_cal SHALL pulse for exactly one cycle, the cycle after LOAD, with parameters already stable.
REQ-022 Parameter outputs SHALL stay constant from LOAD through the end of WAIT_IDLE.
REQ-023 WAIT_RES: first i_valid SHALL latch i_result to o_res_data, with o_res_valid high exactly one cycle and o_res_idx equal to the job index (0-based, wrapping at 16); extra i_valid pulses SHALL be ignored.
REQ-024 WAIT_IDLE: skip the first cycle, then i_busy==0 SHALL go to LOAD when FIFO non-empty, else DONE.
REQ-025 Jobs pushed during a run SHALL execute in the same run if present when WAIT_IDLE exits.
REQ-026 DONE: o_done SHALL be 1 for one cycle, then IDLE; the job index SHALL clear.
REQ-027 o_busy SHALL be 1 in every state except IDLE.
REQ-028 i_go with an empty FIFO SHALL execute SET_T/WAIT_T, then DONE.

Reset
REQ-029 rst SHALL force IDLE, empty the FIFO, zero the index and all outputs; o_job_ready SHALL be 1 the cycle after rst is released.
REQ-030 rst asserted mid-run SHALL abort without emitting o_res_valid or o_done.

Configuration
REQ-031 With SW_SEQ_WATCHDOG_EN defined, a counter SHALL run in WAIT_T, WAIT_RES and WAIT_IDLE. Reaching WD_CYCLES SHALL flush the FIFO, assert o_res_valid with o_res_data all-ones for one cycle, and go to DONE.
REQ-032 Without SW_SEQ_WATCHDOG_EN, there SHALL be no counter and the wait states SHALL wait indefinitely.

Structure
REQ-033 FSM state encoding, parameter field offsets and the all-ones timeout code SHALL reside in shared package sw_seq_pkg; `V_E_F_Bit SHALL come from util.v.
REQ-034 The FIFO SHALL be sub-module sw_param_fifo (push/pop/full/empty, 16-bit data).

Verification
REQ-035 Reset, push 0x5311, i_go, engine model busy 10 cycles after set_t -> one o_set_t pulse; param outputs 5/3/1/1 before o_start_cal; result 42 -> o_res_data=42, idx=0, then o_done.
REQ-036 Push 0x5311 and 0x2122, one i_go -> two start pulses; idx 0 then 1; params change only between jobs.
REQ-037 Push DEPTH+1 words -> o_job_ready low after DEPTH; extra word dropped; DEPTH results.
REQ-038 i_go with empty FIFO -> set_t pulse, o_done, no o_start_cal.
REQ-039 rst during WAIT_RES -> IDLE next cycle, o_busy=0, no o_done.
REQ-040 With SW_SEQ_WATCHDOG_EN and WD_CYCLES=100, busy stuck high -> all-ones result at cycle 100, o_done, FIFO empty.

Source files
------------

// File: rtl/sw_seq_pkg.sv
// ============================================================================
//  sw_seq_pkg
//  FSM encoding, job-word field layout and timeout code for sw_job_sequencer.
//  Revision: 1.0
// ============================================================================
`include "util.v"
`default_nettype none

package sw_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SET_T     = 3'd1,
        ST_WAIT_T    = 3'd2,
        ST_LOAD      = 3'd3,
        ST_START     = 3'd4,
        ST_WAIT_RES  = 3'd5,
        ST_WAIT_IDLE = 3'd6,
        ST_DONE      = 3'd7
    } seq_state_t;

    localparam int RES_W        = `V_E_F_Bit;
    localparam int JOB_W        = 16;
    localparam int FIELD_W      = 4;
    localparam int MATCH_LSB    = 12;
    localparam int MISMATCH_LSB = 8;
    localparam int ALPHA_LSB    = 4;
    localparam int BETA_LSB     = 0;

    // Score reported when the engine never answers
    localparam logic [RES_W-1:0] TIMEOUT_CODE = '1;

    // Extract one 4-bit scoring field from a job word
    function automatic logic [FIELD_W-1:0] job_field(input logic [JOB_W-1:0] job,
                                                     input int lsb);
        return job[lsb +: FIELD_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/sw_param_fifo.sv
// ============================================================================
//  sw_param_fifo
//  Synchronous job FIFO with extra-bit pointers; full pushes and empty pops
//  are dropped. i_flush empties the queue and takes priority over push/pop.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sw_param_fifo
    import sw_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = JOB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (wr_ptr_q == rd_ptr_q);
    assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update: flush resets both, otherwise advance on accepted ops
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/util.v
// ============================================================================
//  util.v
//  Shared width definitions for the alignment-engine sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef V_E_F_Bit
`define V_E_F_Bit 16
`endif

`default_nettype wire

// File: rtl/sw_job_sequencer.sv
// ============================================================================
//  sw_job_sequencer
//  Queues scoring-parameter jobs and runs them one at a time on an alignment
//  engine: set-target, load params, start, capture score, wait engine idle.
//  Optional watchdog: define SW_SEQ_WATCHDOG_EN to abort stuck waits after
//  WD_CYCLES cycles with an all-ones score.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module sw_job_sequencer
    import sw_seq_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int WD_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_job_valid,
    input  logic [15:0]      i_job_param,
    output logic             o_job_ready,
    input  logic             i_go,
    output logic             o_set_t,
    output logic             o_start_cal,
    output logic [3:0]       o_match,
    output logic [3:0]       o_mismatch,
    output logic [3:0]       o_minusAlpha,
    output logic [3:0]       o_minusBeta,
    input  logic             i_busy,
    input  logic             i_valid,
    input  logic [RES_W-1:0] i_result,
    output logic             o_res_valid,
    output logic [RES_W-1:0] o_res_data,
    output logic [3:0]       o_res_idx,
    output logic             o_busy,
    output logic             o_done
);

    seq_state_t       state_q, state_d;
    logic             skip_q, skip_d;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       mismatch_q, mismatch_d;
    logic [3:0]       alpha_q, alpha_d;
    logic [3:0]       beta_q, beta_d;
    logic             res_valid_q, res_valid_d;
    logic [RES_W-1:0] res_data_q, res_data_d;
    logic [3:0]       res_idx_q, res_idx_d;

    logic             w_fifo_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [JOB_W-1:0] w_fifo_data;
    logic             w_wd_fire;

    sw_param_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (JOB_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (i_job_valid),
        .i_data  (i_job_param),
        .i_pop   (w_fifo_pop),
        .i_flush (w_wd_fire),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef SW_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            w_in_wait;

    assign w_in_wait = (state_q == ST_WAIT_T) || (state_q == ST_WAIT_RES) ||
                       (state_q == ST_WAIT_IDLE);
    assign w_wd_fire = w_in_wait && (wd_cnt_q == WD_W'(WD_CYCLES - 1));

    // Count cycles spent in the current wait state; restart on any transition
    always_comb begin
        wd_cnt_d = '0;
        if (w_in_wait && (state_d == state_q)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk) begin
        if (rst) wd_cnt_q <= '0;
        else     wd_cnt_q <= wd_cnt_d;
    end
`else
    logic w_unused_wd;

    assign w_wd_fire   = 1'b0;
    assign w_unused_wd = (WD_CYCLES == 0) ^ (&TIMEOUT_CODE);
`endif

    assign o_job_ready  = !w_fifo_full;
    assign o_set_t      = (state_q == ST_SET_T);
    assign o_start_cal  = (state_q == ST_START);
    assign o_done       = (state_q == ST_DONE);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_match      = match_q;
    assign o_mismatch   = mismatch_q;
    assign o_minusAlpha = alpha_q;
    assign o_minusBeta  = beta_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_data   = res_data_q;
    assign o_res_idx    = res_idx_q;

    // Next-state, FIFO pop, parameter load and result capture
    always_comb begin
        state_d     = state_q;
        skip_d      = 1'b0;
        idx_d       = idx_q;
        match_d     = match_q;
        mismatch_d  = mismatch_q;
        alpha_d     = alpha_q;
        beta_d      = beta_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        w_fifo_pop  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_go) state_d = ST_SET_T;
            end
            ST_SET_T: begin
                state_d = ST_WAIT_T;
                skip_d  = 1'b1;
            end
            ST_WAIT_T: begin
                // The engine needs a cycle to raise busy after set_t
                if (!skip_q && !i_busy) begin
                    state_d = w_fifo_empty ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_fifo_pop = 1'b1;
                match_d    = job_field(w_fifo_data, MATCH_LSB);
                mismatch_d = job_field(w_fifo_data, MISMATCH_LSB);
                alpha_d    = job_field(w_fifo_data, ALPHA_LSB);
                beta_d     = job_field(w_fifo_data, BETA_LSB);
                state_d    = ST_START;
            end
            ST_START: begin
                state_d = ST_WAIT_RES;
            end
            ST_WAIT_RES: begin
                if (i_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = i_result;
                    res_idx_d   = idx_q;
                    state_d     = ST_WAIT_IDLE;
                    skip_d      = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                // Later i_valid pulses are ignored here; only busy matters
                if (!skip_q && !i_busy) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = w_fifo_empty ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                idx_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_wd_fire) begin
            res_valid_d = 1'b1;
            res_data_d  = TIMEOUT_CODE;
            res_idx_d   = idx_q;
            state_d     = ST_DONE;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            skip_q      <= 1'b0;
            idx_q       <= '0;
            match_q     <= '0;
            mismatch_q  <= '0;
            alpha_q     <= '0;
            beta_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            idx_q       <= idx_d;
            match_q     <= match_d;
            mismatch_q  <= mismatch_d;
            alpha_q     <= alpha_d;
            beta_q      <= beta_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sw_job_sequencer.sv
// ============================================================================
//  tb_sw_job_sequencer
//  Scoreboard bench: stimulus queues expected params/results, a negedge
//  monitor pops and compares on o_start_cal / o_res_valid. A small engine
//  model answers set_t and start_cal.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sw_job_sequencer;

    localparam int RW    = sw_seq_pkg::RES_W;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [RW-1:0] data;
        logic [3:0]    idx;
        logic          chk_par;
    } res_exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_job_valid;
    logic [15:0]   i_job_param;
    logic          o_job_ready;
    logic          i_go;
    logic          o_set_t;
    logic          o_start_cal;
    logic [3:0]    o_match, o_mismatch, o_minusAlpha, o_minusBeta;
    logic          i_busy;
    logic          i_valid;
    logic [RW-1:0] i_result;
    logic          o_res_valid;
    logic [RW-1:0] o_res_data;
    logic [3:0]    o_res_idx;
    logic          o_busy;
    logic          o_done;

    sw_job_sequencer #(
        .DEPTH     (DEPTH),
        .WD_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_job_valid  (i_job_valid),
        .i_job_param  (i_job_param),
        .o_job_ready  (o_job_ready),
        .i_go         (i_go),
        .o_set_t      (o_set_t),
        .o_start_cal  (o_start_cal),
        .o_match      (o_match),
        .o_mismatch   (o_mismatch),
        .o_minusAlpha (o_minusAlpha),
        .o_minusBeta  (o_minusBeta),
        .i_busy       (i_busy),
        .i_valid      (i_valid),
        .i_result     (i_result),
        .o_res_valid  (o_res_valid),
        .o_res_data   (o_res_data),
        .o_res_idx    (o_res_idx),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_set = 0, n_start = 0, n_res = 0, n_done = 0;
    int cyc = 0, t_set = 0, t_res = 0;
    logic stuck = 1'b0;

    logic [15:0]   par_exp_q[$];
    logic [RW-1:0] eng_res_q[$];
    res_exp_t      res_exp_q[$];
    logic [15:0]   cur_job = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Engine model: busy after set_t, score a few cycles after start_cal,
    // plus a stray second valid that the sequencer must ignore
    initial begin
        int busy_cnt = 0, valid_at = 0, extra_at = 0;
        i_busy = 1'b0; i_valid = 1'b0; i_result = '0;
        forever begin
            @(negedge clk);
            i_valid = 1'b0;
            if (rst) begin
                busy_cnt = 0; valid_at = 0; extra_at = 0;
            end else begin
                if (busy_cnt > 0) busy_cnt--;
                if (valid_at > 0) begin
                    valid_at--;
                    if (valid_at == 0) begin
                        i_valid  = 1'b1;
                        i_result = (eng_res_q.size() > 0) ? eng_res_q.pop_front() : RW'('hBAD);
                    end
                end
                if (extra_at > 0) begin
                    extra_at--;
                    if (extra_at == 0) begin
                        i_valid  = 1'b1;
                        i_result = RW'('hDEAD);
                    end
                end
                if (o_set_t) busy_cnt = 10;
                if (o_start_cal) begin
                    busy_cnt = 8; valid_at = 3; extra_at = 5;
                end
            end
            i_busy = (busy_cnt > 0) || stuck;
        end
    end

    // Monitor / scoreboard
    initial begin
        res_exp_t r;
        logic [15:0] e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (o_set_t) begin n_set++; t_set = cyc; end
                if (o_done) n_done++;
                if (o_start_cal) begin
                    n_start++;
                    if (par_exp_q.size() == 0) chk("start_unexpected", par_exp_q.size(), 1);
                    else begin
                        e = par_exp_q.pop_front();
                        chk("start_params", {o_match, o_mismatch, o_minusAlpha, o_minusBeta}, e);
                        cur_job = e;
                    end
                end
                if (o_res_valid) begin
                    n_res++; t_res = cyc;
                    if (res_exp_q.size() == 0) chk("res_unexpected", res_exp_q.size(), 1);
                    else begin
                        r = res_exp_q.pop_front();
                        chk("res_data", o_res_data, r.data);
                        chk("res_idx", o_res_idx, r.idx);
                        if (r.chk_par)
                            chk("params_held", {o_match, o_mismatch, o_minusAlpha, o_minusBeta}, cur_job);
                    end
                end
            end
        end
    end

    task automatic push_raw(input logic [15:0] w);
        @(posedge clk); #1;
        i_job_valid = 1'b1; i_job_param = w;
        @(posedge clk); #1;
        i_job_valid = 1'b0;
    endtask

    task automatic push_job(input logic [15:0] w, input logic [RW-1:0] res, input logic [3:0] idx);
        par_exp_q.push_back(w);
        eng_res_q.push_back(res);
        res_exp_q.push_back('{data: res, idx: idx, chk_par: 1'b1});
        push_raw(w);
    endtask

    task automatic go();
        @(posedge clk); #1; i_go = 1'b1;
        @(posedge clk); #1; i_go = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = n_done;
        int k  = 0;
        while (n_done == d0 && k < budget) begin
            @(posedge clk); k++;
        end
        chk("done_seen", (n_done != d0), 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        int s0, r0, d0, st0, k;
        rst = 1'b1; i_job_valid = 1'b0; i_job_param = '0; i_go = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_job_ready", o_job_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_res_valid", o_res_valid, 0);
        chk("rst_params", {o_match, o_mismatch, o_minusAlpha, o_minusBeta, o_set_t, o_start_cal}, 0);

        // Single job
        s0 = n_set; st0 = n_start; r0 = n_res; d0 = n_done;
        push_job(16'h5311, RW'(42), 4'd0);
        go();
        wait_done(300);
        chk("a_set_pulses", n_set - s0, 1);
        chk("a_starts", n_start - st0, 1);
        chk("a_results", n_res - r0, 1);
        chk("a_idle_after", o_busy, 0);

        // Two jobs in one run
        st0 = n_start; r0 = n_res;
        push_job(16'h5311, RW'(7), 4'd0);
        push_job(16'h2122, RW'(9), 4'd1);
        go();
        wait_done(400);
        chk("b_starts", n_start - st0, 2);
        chk("b_results", n_res - r0, 2);

        // Overfill: DEPTH accepted, one dropped
        st0 = n_start; r0 = n_res;
        for (int i = 0; i < DEPTH; i++)
            push_job(16'h1000 * (i + 1) + 16'h0123, RW'(100 + i), 4'(i));
        @(negedge clk);
        chk("c_full_not_ready", o_job_ready, 0);
        push_raw(16'hFFFF);
        go();
        wait_done(800);
        chk("c_starts", n_start - st0, DEPTH);
        chk("c_results", n_res - r0, DEPTH);

        // Empty run
        s0 = n_set; st0 = n_start; d0 = n_done;
        go();
        wait_done(300);
        chk("d_set_pulses", n_set - s0, 1);
        chk("d_no_start", n_start - st0, 0);

        // Reset while waiting for the result
        st0 = n_start;
        push_job(16'h7654, RW'(55), 4'd0);
        go();
        k = 0;
        while (n_start == st0 && k < 300) begin @(posedge clk); k++; end
        chk("e_start_seen", (n_start != st0), 1);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        res_exp_q.delete();
        eng_res_q.delete();
        r0 = n_res; d0 = n_done;
        @(negedge clk);
        chk("e_busy_cleared", o_busy, 0);
        chk("e_fifo_empty", o_job_ready, 1);
        repeat (30) @(posedge clk);
        chk("e_no_done", n_done - d0, 0);
        chk("e_no_result", n_res - r0, 0);

`ifdef SW_SEQ_WATCHDOG_EN
        // Engine stuck busy: watchdog timeout
        stuck = 1'b1;
        push_raw(16'h1234);
        res_exp_q.push_back('{data: {RW{1'b1}}, idx: 4'd0, chk_par: 1'b0});
        r0 = n_res;
        go();
        wait_done(400);
        chk("w_timeout_result", n_res - r0, 1);
        chk("w_latency", t_res - t_set, 101);
        stuck = 1'b0;
        repeat (15) @(posedge clk);
        st0 = n_start;
        go();
        wait_done(300);
        chk("w_fifo_flushed", n_start - st0, 0);
`endif

        chk("queues_drained", par_exp_q.size() + res_exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
